fifo_replay: RTL and testbench

Synchronous single-clock FIFO with valid/ready handshakes on both sides.
- Arbitrary (non-power-of-two) depth.
- Runtime-programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Read-side replay: popped entries stay held until the consumer releases them, and rewind re-reads them. This replaces the old circular-read mode.
- Sits between a streaming producer and a consumer that may need to retransmit, e.g. a packet framer or DMA retry.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mod_ptr.sv | 19 +
 rtl/fifo_replay.sv | 78 +++++++
 tb/tb_fifo_replay.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared status type and modulo increment helper for fifo_replay
package fifo_pkg;
  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic full;
    logic almost_full;
  } fifo_status_t;
  function automatic logic [31:0] mod_inc(input logic [31:0] value, input logic [31:0] modulus);
    return (value == modulus - 32'd1) ? 32'd0 : value + 32'd1;
  endfunction
endpackage

// File: rtl/fifo_mod_ptr.sv
// fifo_mod_ptr: modulo-DEPTH pointer with increment and load
module fifo_mod_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 24,
  parameter int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_value,
  output logic [PW-1:0] value
);
  always_ff @(posedge clk)
    if (reset) value <= '0;
    else if (load) value <= load_value;
    else if (inc) value <= PW'(mod_inc(32'(value), 32'(DEPTH)));
endmodule

// File: rtl/fifo_replay.sv
// fifo_replay: valid/ready FIFO whose popped entries are held for replay until released
module fifo_replay
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 24,
  parameter int AUTO_RELEASE = 0,
  parameter int FILLBITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                release_entries,
  input  logic                rewind,
  input  logic [FILLBITS-1:0] af_thresh,
  input  logic [FILLBITS-1:0] ae_thresh,
  output logic [FILLBITS-1:0] stored_level,
  output logic [FILLBITS-1:0] unread_level,
  output logic                full,
  output logic                almost_full,
  output logic                empty,
  output logic                almost_empty,
  output logic                overflow_err,
  output logic                underflow_err
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [FILLBITS-1:0] FULL_LVL = FILLBITS'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd, base, rd_popped;
  logic [FILLBITS-1:0] stored, unread, unread_after, stored_next;
  logic push, pop, rel, rew;
  fifo_status_t st;
  assign in_ready = !reset && stored != FULL_LVL;
  assign out_valid = unread != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready && !reset;
  assign rel = AUTO_RELEASE != 0 || release_entries;
  assign rew = AUTO_RELEASE == 0 && rewind;
  assign rd_popped = pop ? PW'(mod_inc(32'(rd), 32'(DEPTH))) : rd;
  assign unread_after = unread + FILLBITS'(push) - FILLBITS'(pop);
  // releasing frees everything already popped, so only unread entries stay stored
  assign stored_next = rel ? unread_after : stored + FILLBITS'(push);
  fifo_mod_ptr #(.DEPTH(DEPTH)) u_wr (
    .clk(clk), .reset(reset), .inc(push), .load(1'b0), .load_value('0), .value(wr)
  );
  fifo_mod_ptr #(.DEPTH(DEPTH)) u_rd (
    .clk(clk), .reset(reset), .inc(pop), .load(rew),
    .load_value(rel ? rd_popped : base), .value(rd)
  );
  fifo_mod_ptr #(.DEPTH(DEPTH)) u_base (
    .clk(clk), .reset(reset), .inc(1'b0), .load(rel), .load_value(rd_popped), .value(base)
  );
  always_ff @(posedge clk)
    if (push) mem[wr] <= in_data;
  always_ff @(posedge clk)
    if (reset) begin
      stored <= '0;
      unread <= '0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      stored <= stored_next;
      unread <= rew ? stored_next : unread_after;
      overflow_err <= overflow_err | (in_valid && !in_ready);
      underflow_err <= underflow_err | (out_ready && !out_valid);
    end
  assign st = '{empty: unread == '0, almost_empty: unread <= ae_thresh,
                full: stored == FULL_LVL, almost_full: stored >= af_thresh};
  assign {empty, almost_empty, full, almost_full} = st;
  assign out_data = mem[rd];
  assign stored_level = stored;
  assign unread_level = unread;
endmodule

// File: tb/tb_fifo_replay.sv
// tb_fifo_replay: directed scoreboard bench for auto-release and replay configurations
module tb_fifo_replay;
  localparam int W = 8, D = 24, FB = $clog2(D + 1);
  logic clk = 0, reset = 1;
  logic [W-1:0] a_in_data = 0, a_out_data, m_in_data = 0, m_out_data;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_rel = 0, a_rew = 0;
  logic m_in_valid = 0, m_in_ready, m_out_valid, m_out_ready = 0, m_rel = 0, m_rew = 0;
  logic [FB-1:0] a_af = 5'd24, a_ae = 5'd0, m_af = 5'd20, m_ae = 5'd2;
  logic [FB-1:0] a_stored, a_unread, m_stored, m_unread;
  logic a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
  logic m_full, m_afull, m_empty, m_aempty, m_ovf, m_unf;
  int checks = 0, errors = 0;
  logic [W-1:0] qa[$], qm[$];

  always #5 clk = ~clk;

  fifo_replay #(.WIDTH(W), .DEPTH(D), .AUTO_RELEASE(1)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .release_entries(a_rel), .rewind(a_rew), .af_thresh(a_af), .ae_thresh(a_ae),
    .stored_level(a_stored), .unread_level(a_unread), .full(a_full), .almost_full(a_afull),
    .empty(a_empty), .almost_empty(a_aempty), .overflow_err(a_ovf), .underflow_err(a_unf)
  );
  fifo_replay #(.WIDTH(W), .DEPTH(D), .AUTO_RELEASE(0)) dut_m (
    .clk(clk), .reset(reset), .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .release_entries(m_rel), .rewind(m_rew), .af_thresh(m_af), .ae_thresh(m_ae),
    .stored_level(m_stored), .unread_level(m_unread), .full(m_full), .almost_full(m_afull),
    .empty(m_empty), .almost_empty(m_aempty), .overflow_err(m_ovf), .underflow_err(m_unf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: samples handshakes on the falling edge, before the edge that commits them
  initial forever begin
    @(negedge clk);
    if (!reset && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_pop", 32'(a_out_data), 32'hffff_ffff);
      else chk("a_pop_data", 32'(a_out_data), 32'(qa.pop_front()));
    end
    if (!reset && m_out_valid && m_out_ready) begin
      if (qm.size() == 0) chk("m_unexpected_pop", 32'(m_out_data), 32'hffff_ffff);
      else chk("m_pop_data", 32'(m_out_data), 32'(qm.pop_front()));
    end
  end

  task automatic m_push(input logic [W-1:0] v);
    m_in_valid = 1; m_in_data = v; step(); m_in_valid = 0;
  endtask

  task automatic m_pop(input logic [W-1:0] v, input logic rel);
    m_out_ready = 1; m_rel = rel; qm.push_back(v); step(); m_out_ready = 0; m_rel = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_a_in_ready", 32'(a_in_ready), 0);
    chk("rst_m_in_ready", 32'(m_in_ready), 0);
    chk("rst_m_empty", 32'(m_empty), 1);
    chk("rst_m_aempty", 32'(m_aempty), 1);
    chk("rst_m_afull", 32'(m_afull), 0);
    reset = 0; step();
    chk("post_rst_a_in_ready", 32'(a_in_ready), 1);
    chk("post_rst_a_stored", 32'(a_stored), 0);
    chk("post_rst_a_full", 32'(a_full), 0);
    chk("post_rst_a_errs", {30'd0, a_ovf, a_unf}, 0);
    // auto-release: fill, overflow, drain across the wrap
    for (int i = 0; i < D; i++) begin
      a_in_valid = 1; a_in_data = W'(i); step();
    end
    a_in_valid = 0;
    chk("a_full", 32'(a_full), 1);
    chk("a_in_ready_full", 32'(a_in_ready), 0);
    chk("a_stored_full", 32'(a_stored), 24);
    a_in_valid = 1; a_in_data = 8'h99; step(); a_in_valid = 0;
    chk("a_overflow", 32'(a_ovf), 1);
    chk("a_stored_after_ovf", 32'(a_stored), 24);
    for (int i = 0; i < D; i++) begin
      a_out_ready = 1; qa.push_back(W'(i)); step();
    end
    a_out_ready = 0;
    chk("a_drained_empty", 32'(a_empty), 1);
    chk("a_drained_stored", 32'(a_stored), 0);
    a_in_valid = 1; a_in_data = 8'h11; step(); a_in_valid = 0;
    chk("a_latency_valid", 32'(a_out_valid), 1);
    chk("a_latency_data", 32'(a_out_data), 32'h11);
    a_out_ready = 1; qa.push_back(8'h11); step(); a_out_ready = 0;
    chk("a_pop_empty", 32'(a_empty), 1);
    chk("a_no_underflow", 32'(a_unf), 0);
    // replay: pop 3 then rewind
    for (int i = 1; i <= 5; i++) m_push(W'(i));
    for (int i = 1; i <= 3; i++) m_pop(W'(i), 0);
    chk("m_unread_3pops", 32'(m_unread), 2);
    chk("m_stored_3pops", 32'(m_stored), 5);
    m_rew = 1; step(); m_rew = 0;
    chk("m_rewind_unread", 32'(m_unread), 5);
    for (int i = 1; i <= 5; i++) m_pop(W'(i), 0);
    m_rel = 1; step(); m_rel = 0;
    chk("m_release_stored", 32'(m_stored), 0);
    // partial release then rewind to the oldest held entry
    for (int i = 1; i <= 5; i++) m_push(W'(i));
    for (int i = 1; i <= 3; i++) m_pop(W'(i), 0);
    m_rel = 1; step(); m_rel = 0;
    m_pop(8'd4, 0);
    m_rew = 1; step(); m_rew = 0;
    chk("m_rw_data", 32'(m_out_data), 4);
    chk("m_rw_stored", 32'(m_stored), 2);
    chk("m_rw_unread", 32'(m_unread), 2);
    m_pop(8'd4, 0);
    m_pop(8'd5, 1);
    chk("m_rel_with_pop", 32'(m_stored), 0);
    // release and rewind together with a pop: no replay
    for (int i = 6; i <= 9; i++) m_push(W'(i));
    m_pop(8'd6, 0);
    m_rew = 1; m_pop(8'd7, 1); m_rew = 0;
    chk("m_relrew_data", 32'(m_out_data), 8);
    chk("m_relrew_unread", 32'(m_unread), 2);
    chk("m_relrew_stored", 32'(m_stored), 2);
    m_pop(8'd8, 0);
    m_pop(8'd9, 1);
    // thresholds
    for (int i = 0; i < 19; i++) m_push(W'(8'h40 + i));
    chk("m_afull_19", 32'(m_afull), 0);
    m_push(8'h53);
    chk("m_afull_20", 32'(m_afull), 1);
    chk("m_aempty_20", 32'(m_aempty), 0);
    for (int i = 0; i < 17; i++) m_pop(W'(8'h40 + i), 1);
    chk("m_aempty_3", 32'(m_aempty), 0);
    m_pop(8'h51, 1);
    chk("m_aempty_2", 32'(m_aempty), 1);
    chk("m_stored_2", 32'(m_stored), 2);
    chk("m_afull_2", 32'(m_afull), 0);
    // reset mid-stream, producer still pushing
    reset = 1; m_in_valid = 1; step();
    chk("midrst_in_ready", 32'(m_in_ready), 0);
    chk("midrst_empty", 32'(m_empty), 1);
    reset = 0; m_in_valid = 0; step();
    chk("postrst_in_ready", 32'(m_in_ready), 1);
    chk("postrst_errs", {30'd0, m_ovf, m_unf}, 0);
    chk("postrst_stored", 32'(m_stored), 0);
    m_out_ready = 1; step(); m_out_ready = 0;
    chk("m_underflow", 32'(m_unf), 1);
    chk("m_ovf_clear", 32'(m_ovf), 0);
    step();
    chk("qa_drained", qa.size(), 0);
    chk("qm_drained", qm.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
